video_clock_sequencer: RTL and testbench
========================================

VIDEO_CLOCK_SEQUENCER -- requirements
Module: video_clock_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16: cycles video reset is held low before the config changes.
REQ-002 SHALL have parameter UNLOCK_WAIT, default 64: max cycles to wait for the synchronized lock to drop after a config change.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1048576: max cycles to wait for lock to rise.
REQ-004 SHALL have parameter SETTLE, default 1024: cycles lock must stay continuously high before video reset is released.
REQ-005 SHALL have one clock, clk27; reset is rstn, asynchronous, active-low.
REQ-006 Ports: clk27 input 1: 27 MHz reference clock, sole clock.
REQ-007 Ports: rstn input 1: async active-low reset.
REQ-008 Ports: req_config input 4: requested pixel-clock code, using the PIXEL_CLOCK_* codes.
REQ-009 Ports: req_valid input 1: request strobe.
REQ-010 Ports: req_ready output 1: high only in RUN and FAIL; a request is accepted when req_valid and req_ready are both high on a clock edge.
REQ-011 Ports: lock input 1: PLL lock, asynchronous to clk27.
REQ-012 Ports: clock_config output 4: code driven to the clock generator.
REQ-013 Ports: video_rstn output 1: active-low reset for the pixel/serial domains.
REQ-014 Ports: busy output 1: high in every state except RUN and FAIL.
REQ-015 Ports: timeout_err output 1: sticky lock-timeout flag.

Function
REQ-016 lock SHALL pass through a 2-flop synchronizer; lock_s below means the synchronized value (2 cycles latency).
REQ-017 FSM states SHALL be: RST_ASSERT, SWITCH, WAIT_UNLOCK, WAIT_LOCK, SETTLE_ST, RUN, FAIL.
REQ-018 RST_ASSERT: video_rstn=0; after RST_HOLD cycles -> SWITCH.
REQ-019 SWITCH (1 cycle): clock_config <= pending code; cycle counter cleared -> WAIT_UNLOCK.
REQ-020 WAIT_UNLOCK: -> WAIT_LOCK when lock_s=0 or UNLOCK_WAIT cycles have elapsed, whichever comes first.
REQ-021 WAIT_LOCK: -> SETTLE_ST when lock_s=1; if LOCK_TIMEOUT cycles elapse first -> FAIL and timeout_err set to 1.
REQ-022 SETTLE_ST: counter increments while lock_s=1; any cycle with lock_s=0 -> WAIT_LOCK with counter cleared; after SETTLE consecutive high cycles -> RUN.
REQ-023 RUN: video_rstn=1; if lock_s=0 for 1 cycle -> RST_ASSERT with the same pending code (relock).
REQ-024 FAIL: video_rstn=0 and clock_config held.
REQ-025 An accepted request in RUN or FAIL SHALL latch req_config as pending, clear timeout_err and -> RST_ASSERT on the next cycle.
REQ-026 req_valid SHALL be ignored while busy=1; there is no queue.
REQ-027 A request for the code already driven SHALL still run the full sequence.
REQ-028 When a request is accepted in RUN and lock_s=0 on the same cycle, the request SHALL win.
REQ-029 video_rstn SHALL be a registered output, never combinational.
REQ-030 The cycle counter SHALL be 21 bits wide and saturating; it is cleared on every state entry.

Reset
REQ-031 While rstn=0: state=RST_ASSERT; pending and clock_config=PIXEL_CLOCK_126; video_rstn=0; timeout_err=0; counter=0; synchronizer flops=0.
REQ-032 After reset deassertion, the full sequence SHALL run for PIXEL_CLOCK_126 without any request.
REQ-033 If rstn is asserted mid-sequence, the sequencer SHALL abort immediately and restart from REQ-031.

Structure
REQ-034 The PIXEL_CLOCK_* codes SHALL come from the shared video timing header; the state encoding SHALL be a localparam set in that header.
REQ-035 The synchronizer SHALL be one sub-module, sync_2ff, reused for other async inputs.
REQ-036 video_clock SHALL consume clock_config; video_rstn SHALL replace hdmi_rstn_o gating.

Verification
REQ-037 Scenario: reset release, lock rises at cycle 100 -> clock_config=PIXEL_CLOCK_126 and video_rstn=1 at cycle 100+2+SETTLE (±1).
REQ-038 Scenario: RUN, request PIXEL_CLOCK_325 -> video_rstn=0 next cycle; clock_config changes after 16 cycles; busy=1 until relock+settle.
REQ-039 Scenario: lock never drops after switch -> WAIT_LOCK entered 64 cycles after SWITCH; lock high -> RUN after SETTLE cycles.
REQ-040 Scenario: lock glitches low at settle count 500 -> counter restarts; RUN only after 1024 consecutive high cycles.
REQ-041 Scenario: lock held low -> FAIL with timeout_err=1 after 1048576 cycles; a new request clears timeout_err.
REQ-042 Scenario: lock drops in RUN -> video_rstn=0 within 3 cycles, sequence reruns with the unchanged clock_config; req_valid while busy is ignored.

Source files
------------

// File: rtl/video_clock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_clock_sequencer_pkg
// Description : Shared video timing header: pixel-clock codes, sequencer
//               state encoding and counter helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package video_clock_sequencer_pkg;

    localparam int CFG_W = 4;
    localparam int CNT_W = 21;

    typedef logic [CFG_W-1:0] pixel_clock_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam pixel_clock_t PIXEL_CLOCK_25  = 4'h0;
    localparam pixel_clock_t PIXEL_CLOCK_74  = 4'h1;
    localparam pixel_clock_t PIXEL_CLOCK_126 = 4'h2;
    localparam pixel_clock_t PIXEL_CLOCK_148 = 4'h3;
    localparam pixel_clock_t PIXEL_CLOCK_325 = 4'h4;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_RST_ASSERT  = 3'd0;
    localparam seq_state_t ST_SWITCH      = 3'd1;
    localparam seq_state_t ST_WAIT_UNLOCK = 3'd2;
    localparam seq_state_t ST_WAIT_LOCK   = 3'd3;
    localparam seq_state_t ST_SETTLE      = 3'd4;
    localparam seq_state_t ST_RUN         = 3'd5;
    localparam seq_state_t ST_FAIL        = 3'd6;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_clock_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/video_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_clock_sequencer
// Description : Sequences pixel-clock reconfiguration: holds video reset,
//               switches the clock code, waits for PLL relock and settling.
// Revision    : 1.0 - initial release
// ============================================================================
module video_clock_sequencer
    import video_clock_sequencer_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int UNLOCK_WAIT  = 64,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int SETTLE       = 1024
) (
    input  logic             clk27,
    input  logic             rstn,
    input  logic [CFG_W-1:0] req_config,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             lock,
    output logic [CFG_W-1:0] clock_config,
    output logic             video_rstn,
    output logic             busy,
    output logic             timeout_err
);

    localparam cnt_t c_RST_HOLD_LAST = cnt_t'(RST_HOLD - 1);
    localparam cnt_t c_UNLOCK_LAST   = cnt_t'(UNLOCK_WAIT - 1);
    localparam cnt_t c_TIMEOUT_LAST  = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t c_SETTLE_LAST   = cnt_t'(SETTLE - 1);

    logic         w_lock_s;
    logic         w_accept;
    seq_state_t   r_state;
    cnt_t         r_cnt;
    pixel_clock_t r_pending;
    pixel_clock_t r_clock_config;
    logic         r_video_rstn;
    logic         r_timeout_err;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk  (clk27),
        .rstn (rstn),
        .i_d  (lock),
        .o_q  (w_lock_s)
    );

    assign req_ready    = (r_state == ST_RUN) || (r_state == ST_FAIL);
    assign busy         = !req_ready;
    assign w_accept     = req_valid && req_ready;
    assign clock_config = r_clock_config;
    assign video_rstn   = r_video_rstn;
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk27 or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_RST_ASSERT;
            r_cnt          <= '0;
            r_pending      <= PIXEL_CLOCK_126;
            r_clock_config <= PIXEL_CLOCK_126;
            r_video_rstn   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_ASSERT: begin
                    r_video_rstn <= 1'b0;
                    if (r_cnt >= c_RST_HOLD_LAST) begin
                        r_state <= ST_SWITCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_SWITCH: begin
                    r_clock_config <= r_pending;
                    r_state        <= ST_WAIT_UNLOCK;
                    r_cnt          <= '0;
                end
                ST_WAIT_UNLOCK: begin
                    // A PLL that never reports unlock must not stall the switch
                    if (!w_lock_s || (r_cnt >= c_UNLOCK_LAST)) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_TIMEOUT_LAST) begin
                        r_state       <= ST_FAIL;
                        r_timeout_err <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_SETTLE: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_SETTLE_LAST) begin
                        r_state      <= ST_RUN;
                        r_video_rstn <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_RUN: begin
                    // A new request takes priority over a simultaneous lock loss
                    if (w_accept) begin
                        r_pending     <= req_config;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_RST_ASSERT;
                        r_video_rstn  <= 1'b0;
                        r_cnt         <= '0;
                    end else if (!w_lock_s) begin
                        r_state      <= ST_RST_ASSERT;
                        r_video_rstn <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_FAIL: begin
                    r_video_rstn <= 1'b0;
                    if (w_accept) begin
                        r_pending     <= req_config;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_RST_ASSERT;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                default: begin
                    r_state      <= ST_RST_ASSERT;
                    r_video_rstn <= 1'b0;
                    r_cnt        <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_clock_sequencer
// Description : Scoreboard bench for the video clock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_clock_sequencer;
    import video_clock_sequencer_pkg::*;

    localparam int RST_HOLD     = 16;
    localparam int UNLOCK_WAIT  = 64;
    localparam int LOCK_TIMEOUT = 3000;
    localparam int SETTLE       = 1024;

    localparam int EV_RST    = 0;
    localparam int EV_CFG    = 1;
    localparam int EV_ERRCLR = 2;
    localparam int EV_RUN    = 3;
    localparam int EV_FAIL   = 4;

    typedef struct {
        int          kind;
        logic [3:0]  cfg;
        int          cyc;
    } exp_t;

    exp_t  sb[$];
    string ev_name[5] = '{"rst_fall", "cfg_change", "err_clear", "run_entry", "timeout"};

    logic       clk27 = 1'b0;
    logic       rstn;
    logic       lock;
    logic       req_valid;
    logic [3:0] req_config;
    logic       req_ready;
    logic [3:0] clock_config;
    logic       video_rstn;
    logic       busy;
    logic       timeout_err;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic       p_vr;
    logic       p_te;
    logic [3:0] p_cfg;

    video_clock_sequencer #(
        .RST_HOLD     (RST_HOLD),
        .UNLOCK_WAIT  (UNLOCK_WAIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE       (SETTLE)
    ) dut (
        .clk27        (clk27),
        .rstn         (rstn),
        .req_config   (req_config),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .lock         (lock),
        .clock_config (clock_config),
        .video_rstn   (video_rstn),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk27 = ~clk27;

    always @(posedge clk27) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input logic [3:0] cfg, input int c);
        exp_t e;
        e.kind = kind;
        e.cfg  = cfg;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic got(input int kind, input logic [3:0] cfg);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s cfg=%0h at cycle %0d, expected none", ev_name[kind], cfg, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cfg !== cfg || cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                failures++;
                $display("FAIL event_%s: got %s cfg=%0h cycle=%0d, expected %s cfg=%0h cycle=%0d",
                         ev_name[e.kind], ev_name[kind], cfg, cyc, ev_name[e.kind], e.cfg, e.cyc);
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk27);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d events outstanding after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
        tick(2);
    endtask

    task automatic request(input logic [3:0] code);
        req_valid  = 1'b1;
        req_config = code;
        tick(1);
        req_valid  = 1'b0;
    endtask

    // Monitor: turns output transitions into events and checks them in order
    initial begin
        wait (mon_en);
        @(posedge clk27);
        #1;
        p_vr  = video_rstn;
        p_te  = timeout_err;
        p_cfg = clock_config;
        forever begin
            @(posedge clk27);
            #1;
            if (p_vr && !video_rstn)     got(EV_RST, clock_config);
            if (clock_config !== p_cfg)  got(EV_CFG, clock_config);
            if (p_te && !timeout_err)    got(EV_ERRCLR, clock_config);
            if (!p_vr && video_rstn)     got(EV_RUN, clock_config);
            if (!p_te && timeout_err)    got(EV_FAIL, clock_config);
            p_vr  = video_rstn;
            p_te  = timeout_err;
            p_cfg = clock_config;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int m;
        rstn       = 1'b0;
        lock       = 1'b0;
        req_valid  = 1'b0;
        req_config = 4'h0;
        tick(5);
        chk("rst_clock_config", 32'(clock_config), 32'(PIXEL_CLOCK_126));
        chk("rst_video_rstn", 32'(video_rstn), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        mon_en = 1'b1;
        tick(2);

        // Power-up sequence, lock rises 100 cycles after release
        k = cyc;
        push(EV_RUN, PIXEL_CLOCK_126, k + 1127);
        rstn = 1'b1;
        tick(100);
        lock = 1'b1;
        wait_drain(1300);
        chk("run_req_ready", 32'(req_ready), 32'd1);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_video_rstn", 32'(video_rstn), 32'd1);

        // Switch to 325 with lock never dropping; a request while busy is ignored
        k = cyc;
        push(EV_RST, PIXEL_CLOCK_126, k + 1);
        push(EV_CFG, PIXEL_CLOCK_325, k + 18);
        push(EV_RUN, PIXEL_CLOCK_325, k + 1107);
        request(PIXEL_CLOCK_325);
        tick(39);
        chk("seq_busy", 32'(busy), 32'd1);
        chk("seq_req_ready", 32'(req_ready), 32'd0);
        req_valid  = 1'b1;
        req_config = PIXEL_CLOCK_25;
        tick(3);
        req_valid  = 1'b0;
        wait_drain(1300);
        chk("ignored_req_cfg", 32'(clock_config), 32'(PIXEL_CLOCK_325));

        // Same code again; lock glitches low partway through settling
        k = cyc;
        push(EV_RST, PIXEL_CLOCK_325, k + 1);
        push(EV_RUN, PIXEL_CLOCK_325, k + 1561);
        request(PIXEL_CLOCK_325);
        tick(9);
        lock = 1'b0;
        tick(20);
        lock = 1'b1;
        tick(503);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        wait_drain(1800);

        // Request coincides with lock loss in RUN, then lock never returns
        lock = 1'b0;
        tick(2);
        k = cyc;
        push(EV_RST, PIXEL_CLOCK_325, k + 1);
        push(EV_CFG, PIXEL_CLOCK_74, k + 18);
        push(EV_FAIL, PIXEL_CLOCK_74, k + 3019);
        request(PIXEL_CLOCK_74);
        wait_drain(3300);
        chk("fail_timeout_err", 32'(timeout_err), 32'd1);
        chk("fail_req_ready", 32'(req_ready), 32'd1);
        chk("fail_busy", 32'(busy), 32'd0);
        chk("fail_video_rstn", 32'(video_rstn), 32'd0);
        chk("fail_clock_config", 32'(clock_config), 32'(PIXEL_CLOCK_74));

        // Recovery from FAIL clears the error
        m = cyc;
        push(EV_ERRCLR, PIXEL_CLOCK_74, m + 1);
        push(EV_CFG, PIXEL_CLOCK_148, m + 18);
        push(EV_RUN, PIXEL_CLOCK_148, m + 1067);
        request(PIXEL_CLOCK_148);
        tick(39);
        lock = 1'b1;
        wait_drain(1300);
        chk("recover_timeout_err", 32'(timeout_err), 32'd0);

        // Lock drop in RUN triggers a relock with the same code
        k = cyc;
        push(EV_RST, PIXEL_CLOCK_148, k + 3);
        push(EV_RUN, PIXEL_CLOCK_148, k + 1109);
        lock = 1'b0;
        tick(5);
        lock = 1'b1;
        tick(25);
        chk("relock_busy", 32'(busy), 32'd1);
        req_valid  = 1'b1;
        req_config = PIXEL_CLOCK_325;
        tick(3);
        req_valid  = 1'b0;
        wait_drain(1300);
        chk("relock_cfg", 32'(clock_config), 32'(PIXEL_CLOCK_148));

        // Reset asserted mid-sequence aborts and restarts with the default code
        k = cyc;
        push(EV_RST, PIXEL_CLOCK_148, k + 1);
        push(EV_CFG, PIXEL_CLOCK_325, k + 18);
        push(EV_CFG, PIXEL_CLOCK_126, k + 41);
        request(PIXEL_CLOCK_325);
        tick(39);
        rstn = 1'b0;
        tick(1);
        chk("midrst_clock_config", 32'(clock_config), 32'(PIXEL_CLOCK_126));
        chk("midrst_video_rstn", 32'(video_rstn), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        tick(2);
        k = cyc;
        push(EV_RUN, PIXEL_CLOCK_126, k + 1106);
        rstn = 1'b1;
        wait_drain(1300);
        chk("final_video_rstn", 32'(video_rstn), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
